mem_addr_sequencer: RTL and testbench
=====================================

// Module: mem_addr_sequencer
// PURPOSE
//   Sequences every memory access of the multicycle CPU. Arbitrates between
//   instruction fetch, data load/store and exception-vector fetch requests
//   from the control unit. Drives mux_iord_control for the memory address
//   mux and the memory write strobe, absorbs fixed memory latency, and pulses
//   completion/register-load strobes. Sits between the control FSM and the
//   memory/IR/MDR.
// PARAMETERS
//   MEM_LAT     2  memory read/write latency in cycles; legal 1..15
//   STARVE_MAX  3  consecutive lost arbitrations after which fetch is promoted
// PORTS
//   clk               in   1   clock, rising edge
//   reset             in   1   synchronous reset, active-low
//   fetch_req         in   1   instruction fetch request, address = PC
//   data_req          in   1   data access request
//   data_src          in   1   data address source: 0 = ALUOut reg, 1 = ALU result
//   data_we           in   1   data access is a store (1) or load (0)
//   exc_req           in   1   exception vector fetch request
//   mux_iord_control  out  2   00 PC, 01 ALUOut, 10 ALU result, 11 exception
//   mem_wr            out  1   memory write strobe
//   busy              out  1   transaction in progress (state != IDLE)
//   fetch_done        out  1   1-cycle pulse, fetch complete
//   data_done         out  1   1-cycle pulse, load/store complete
//   exc_done          out  1   1-cycle pulse, exception fetch complete
//   ir_load           out  1   load IR (coincides with fetch_done)
//   mdr_load          out  1   load MDR (coincides with data_done and load)
// BEHAVIOUR
// - All outputs are registered. reset=0 at an edge: state IDLE, mux_iord_control=00,
//   all strobes 0, busy 0, starve counter 0. This aborts any transaction in
//   flight; no done pulse is issued.
// - FSM: IDLE -> ACCESS -> DONE -> IDLE.
//   IDLE: if any request is sampled, latch grant/src/we, load the latency
//     counter with MEM_LAT-1 and go to ACCESS. Otherwise stay in IDLE and
//     hold mux_iord_control at 00.
//   ACCESS: lasts exactly MEM_LAT cycles. mux_iord_control holds the granted
//     source. mem_wr=1 on every ACCESS cycle only for a data store, otherwise 0.
//     At count 0, go to DONE.
//   DONE: one cycle. mux_iord_control is still held. Pulse the matching
//     *_done, plus ir_load (fetch) or mdr_load (data load only; a store gives
//     no mdr_load). Then go to IDLE.
// - Latency: request sampled at edge N gives a done pulse in cycle N+MEM_LAT+1.
//   A new grant is possible at the edge that ends DONE, with no dead cycle.
// - Priority at grant: exc_req > data_req > fetch_req. Exception:
//   - when the starve counter is >= STARVE_MAX and fetch_req=1, fetch beats
//     data, but never exc.
//   - the counter increments (saturating) when fetch_req=1 loses a grant;
//     it clears when fetch is granted.
// - Simultaneous events:
//   - requests arriving while busy are ignored until IDLE; a running
//     transaction is never preempted, including by exc_req.
//   - dropping a request mid-transaction still completes it and still pulses
//     done.
// - Requesters hold req until their done pulse and drop it in the following
//   cycle. A req still high in IDLE after done is treated as a new request.
// - data_src and data_we are sampled only at grant.
// - mux code: data_src=0 -> 01, data_src=1 -> 10.
// - MEM_LAT outside 1..15 is a configuration error: a simulation-only
//   $error fires at time 0.
// TESTING
// - Reset: hold reset=0 for 3 cycles with all req=1 -> mux=00, mem_wr=0,
//   busy=0, no done.
// - Fetch, MEM_LAT=2: fetch_req sampled at cycle 0 -> mux=00 in cycles 1-3,
//   fetch_done=ir_load=1 in cycle 3 only.
// - Store via ALU result: data_req=1, data_src=1, data_we=1 -> mux=10,
//   mem_wr=1 in cycles 1-2, data_done in cycle 3, mdr_load=0.
// - Priority: exc, data and fetch all requested at the same edge ->
//   exc_done first (mux=11), then data, then fetch, back-to-back.
// - Starvation, STARVE_MAX=3: fetch_req and data_req held high -> after 3 data
//   grants, the 4th grant is fetch; the counter then clears.
// - Mid-op reset: reset=0 in the 2nd ACCESS cycle of a store -> next cycle is
//   IDLE, mem_wr=0, data_done never pulses.

Source files
------------

// File: rtl/mem_addr_sequencer_if.sv
// mem_addr_sequencer_if
//   Bundle between the CPU control FSM and the memory address sequencer.
//   master : control-unit side (drives requests, observes strobes)
//   slave  : sequencer side (observes requests, drives mux select/strobes)
//   Requests : fetch_req, data_req, data_src, data_we, exc_req
//   Outputs  : mux_iord_control[1:0], mem_wr, busy,
//              fetch_done, data_done, exc_done, ir_load, mdr_load
interface mem_addr_sequencer_if;
  logic       fetch_req;
  logic       data_req;
  logic       data_src;
  logic       data_we;
  logic       exc_req;
  logic [1:0] mux_iord_control;
  logic       mem_wr;
  logic       busy;
  logic       fetch_done;
  logic       data_done;
  logic       exc_done;
  logic       ir_load;
  logic       mdr_load;

  modport master (
    output fetch_req, data_req, data_src, data_we, exc_req,
    input  mux_iord_control, mem_wr, busy,
    input  fetch_done, data_done, exc_done, ir_load, mdr_load
  );

  modport slave (
    input  fetch_req, data_req, data_src, data_we, exc_req,
    output mux_iord_control, mem_wr, busy,
    output fetch_done, data_done, exc_done, ir_load, mdr_load
  );
endinterface

// File: rtl/mem_addr_sequencer.sv
// mem_addr_sequencer
//   Arbitrates fetch / data / exception-vector memory accesses of the
//   multicycle CPU, drives the IorD address mux select and the write strobe,
//   waits out the fixed memory latency and pulses the completion strobes.
// Ports
//   clk_i     : clock, rising edge
//   reset_ni  : synchronous reset, active-low
//   bus       : mem_addr_sequencer_if.slave (requests in, mux/strobes out)
// Parameters
//   MEM_LAT    : memory latency in cycles (1..15)
//   STARVE_MAX : lost arbitrations after which fetch beats data
//
// state  | meaning
// IDLE   | no transaction, mux parked on PC, accepts requests
// ACCESS | memory access in flight for MEM_LAT cycles, mux held
// DONE   | one cycle of done/load strobes, may grant the next request
module mem_addr_sequencer #(
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 3
) (
  input logic                 clk_i,
  input logic                 reset_ni,
  mem_addr_sequencer_if.slave bus
);

  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  localparam logic [1:0] MUX_PC     = 2'b00;
  localparam logic [1:0] MUX_ALUOUT = 2'b01;
  localparam logic [1:0] MUX_ALURES = 2'b10;
  localparam logic [1:0] MUX_EXC    = 2'b11;

  if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_lat_check
    $error("mem_addr_sequencer: MEM_LAT=%0d outside 1..15", MEM_LAT);
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    grant_q, grant_d;
  logic          we_q, we_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [SW-1:0] starve_q, starve_d;

  logic [1:0] mux_q, mux_d;
  logic       mem_wr_q, mem_wr_d;
  logic       busy_q, busy_d;
  logic       fetch_done_q, fetch_done_d;
  logic       data_done_q, data_done_d;
  logic       exc_done_q, exc_done_d;
  logic       ir_load_q, ir_load_d;
  logic       mdr_load_q, mdr_load_d;

  logic       arb_any;
  logic       fetch_wins;
  logic       fetch_granted;
  logic [1:0] arb_code;
  logic       arb_we;

  // Arbitration: exc > data > fetch, except a starved fetch beats data.
  always_comb begin
    fetch_wins    = bus.fetch_req && (!bus.data_req || (starve_q >= SW'(STARVE_MAX)));
    arb_any       = bus.exc_req || bus.data_req || bus.fetch_req;
    arb_code      = MUX_PC;
    arb_we        = 1'b0;
    fetch_granted = 1'b0;
    if (bus.exc_req) begin
      arb_code = MUX_EXC;
    end else if (bus.data_req && !fetch_wins) begin
      arb_code = bus.data_src ? MUX_ALURES : MUX_ALUOUT;
      arb_we   = bus.data_we;
    end else begin
      fetch_granted = bus.fetch_req;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    we_d         = we_q;
    cnt_d        = cnt_q;
    starve_d     = starve_q;
    mux_d        = MUX_PC;
    mem_wr_d     = 1'b0;
    busy_d       = 1'b0;
    fetch_done_d = 1'b0;
    data_done_d  = 1'b0;
    exc_done_d   = 1'b0;
    ir_load_d    = 1'b0;
    mdr_load_d   = 1'b0;
    case (state_q)
      ACCESS: begin
        busy_d = 1'b1;
        mux_d  = grant_q;
        if (cnt_q == 4'd0) begin
          state_d      = DONE;
          fetch_done_d = (grant_q == MUX_PC);
          exc_done_d   = (grant_q == MUX_EXC);
          data_done_d  = (grant_q == MUX_ALUOUT) || (grant_q == MUX_ALURES);
          ir_load_d    = (grant_q == MUX_PC);
          mdr_load_d   = ((grant_q == MUX_ALUOUT) || (grant_q == MUX_ALURES)) && !we_q;
        end else begin
          cnt_d    = cnt_q - 4'd1;
          mem_wr_d = we_q;
        end
      end
      default: begin
        // IDLE and DONE share the grant path so a new access can start at
        // the edge that ends DONE.
        state_d = IDLE;
        if (arb_any) begin
          state_d  = ACCESS;
          grant_d  = arb_code;
          we_d     = arb_we;
          cnt_d    = 4'(MEM_LAT - 1);
          mux_d    = arb_code;
          mem_wr_d = arb_we;
          busy_d   = 1'b1;
          if (bus.fetch_req) begin
            if (fetch_granted) begin
              starve_d = '0;
            end else if (starve_q < SW'(STARVE_MAX)) begin
              starve_d = starve_q + SW'(1);
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q      <= IDLE;
      grant_q      <= MUX_PC;
      we_q         <= 1'b0;
      cnt_q        <= '0;
      starve_q     <= '0;
      mux_q        <= MUX_PC;
      mem_wr_q     <= 1'b0;
      busy_q       <= 1'b0;
      fetch_done_q <= 1'b0;
      data_done_q  <= 1'b0;
      exc_done_q   <= 1'b0;
      ir_load_q    <= 1'b0;
      mdr_load_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      we_q         <= we_d;
      cnt_q        <= cnt_d;
      starve_q     <= starve_d;
      mux_q        <= mux_d;
      mem_wr_q     <= mem_wr_d;
      busy_q       <= busy_d;
      fetch_done_q <= fetch_done_d;
      data_done_q  <= data_done_d;
      exc_done_q   <= exc_done_d;
      ir_load_q    <= ir_load_d;
      mdr_load_q   <= mdr_load_d;
    end
  end

  assign bus.mux_iord_control = mux_q;
  assign bus.mem_wr           = mem_wr_q;
  assign bus.busy             = busy_q;
  assign bus.fetch_done       = fetch_done_q;
  assign bus.data_done        = data_done_q;
  assign bus.exc_done         = exc_done_q;
  assign bus.ir_load          = ir_load_q;
  assign bus.mdr_load         = mdr_load_q;

endmodule

// File: tb/tb_mem_addr_sequencer.sv
module tb_mem_addr_sequencer;
  localparam int MEM_LAT    = 2;
  localparam int STARVE_MAX = 3;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  mem_addr_sequencer_if bus();

  mem_addr_sequencer #(.MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)) dut (
    .clk_i   (clk),
    .reset_ni(reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [2:0] done_vec;  // {exc, data, fetch}
    logic [1:0] mux;
    logic       ir;
    logic       mdr;
    int         wr;
    int         cyc;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic push(input logic [2:0] dv, input logic [1:0] mux, input logic ir,
                      input logic mdr, input int wr, input int c);
    exp_t e;
    e.done_vec = dv; e.mux = mux; e.ir = ir; e.mdr = mdr; e.wr = wr; e.cyc = c;
    sb_q.push_back(e);
  endtask

  // Monitor: tracks each transaction's mux and write cycles, pops on done.
  int         run_wr = 0;
  bit         run_started = 0;
  bit         mux_stable = 1;
  logic [1:0] run_mux;
  logic [2:0] mon_dv;
  exp_t       mon_e;

  always @(negedge clk) begin
    if (bus.busy !== 1'b1) begin
      run_wr = 0; run_started = 0; mux_stable = 1;
    end else begin
      if (!run_started) begin
        run_mux = bus.mux_iord_control; run_started = 1;
      end else if (bus.mux_iord_control !== run_mux) begin
        mux_stable = 0;
      end
      if (bus.mem_wr === 1'b1) run_wr++;
    end
    mon_dv = {bus.exc_done, bus.data_done, bus.fetch_done};
    if ((|mon_dv) === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 32'(mon_dv), 0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("done_vec",   32'(mon_dv), 32'(mon_e.done_vec));
        chk("mux",        32'(run_mux), 32'(mon_e.mux));
        chk("mux_stable", 32'(mux_stable), 1);
        chk("ir_load",    32'(bus.ir_load), 32'(mon_e.ir));
        chk("mdr_load",   32'(bus.mdr_load), 32'(mon_e.mdr));
        chk("wr_cycles",  run_wr, mon_e.wr);
        chk("done_cycle", cyc, mon_e.cyc);
      end
      run_wr = 0; run_started = 0; mux_stable = 1;
    end
  end

  // Waits (bounded) for done bit idx (0 fetch, 1 data, 2 exc); optionally drops that req.
  task automatic wait_done(input int idx, input bit drop);
    bit         seen = 0;
    logic [2:0] dv;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      dv = {bus.exc_done, bus.data_done, bus.fetch_done};
      if (dv[idx] === 1'b1) seen = 1;
    end
    chk($sformatf("done%0d_seen", idx), 32'(seen), 1);
    if (drop) begin
      case (idx)
        0: bus.fetch_req = 1'b0;
        1: bus.data_req  = 1'b0;
        default: bus.exc_req = 1'b0;
      endcase
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    // Reset with every request asserted.
    reset_n = 1'b0;
    bus.fetch_req = 1'b1; bus.data_req = 1'b1; bus.exc_req = 1'b1;
    bus.data_src  = 1'b1; bus.data_we  = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_mux",  32'(bus.mux_iord_control), 0);
      chk("rst_mem_wr", 32'(bus.mem_wr), 0);
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_done", 32'({bus.exc_done, bus.data_done, bus.fetch_done}), 0);
    end
    bus.fetch_req = 1'b0; bus.data_req = 1'b0; bus.exc_req = 1'b0;
    bus.data_src  = 1'b0; bus.data_we  = 1'b0;
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_busy", 32'(bus.busy), 0);

    // Fetch.
    c = cyc;
    push(3'b001, 2'b00, 1'b1, 1'b0, 0, c + MEM_LAT + 1);
    bus.fetch_req = 1'b1;
    wait_done(0, 1);
    repeat (2) @(negedge clk);

    // Store via ALU result; src/we changed after grant must be ignored.
    c = cyc;
    push(3'b010, 2'b10, 1'b0, 1'b0, MEM_LAT, c + MEM_LAT + 1);
    bus.data_req = 1'b1; bus.data_src = 1'b1; bus.data_we = 1'b1;
    @(negedge clk);
    bus.data_src = 1'b0; bus.data_we = 1'b0;
    wait_done(1, 1);
    repeat (2) @(negedge clk);

    // Load via ALUOut.
    c = cyc;
    push(3'b010, 2'b01, 1'b0, 1'b1, 0, c + MEM_LAT + 1);
    bus.data_req = 1'b1; bus.data_src = 1'b0; bus.data_we = 1'b0;
    wait_done(1, 1);
    repeat (2) @(negedge clk);

    // Priority: exc, then data (store via ALUOut), then fetch, back-to-back.
    c = cyc;
    push(3'b100, 2'b11, 1'b0, 1'b0, 0,       c + 1 * (MEM_LAT + 1));
    push(3'b010, 2'b01, 1'b0, 1'b0, MEM_LAT, c + 2 * (MEM_LAT + 1));
    push(3'b001, 2'b00, 1'b1, 1'b0, 0,       c + 3 * (MEM_LAT + 1));
    bus.exc_req = 1'b1; bus.data_req = 1'b1; bus.fetch_req = 1'b1;
    bus.data_src = 1'b0; bus.data_we = 1'b1;
    wait_done(2, 1);
    wait_done(1, 1);
    wait_done(0, 1);
    bus.data_we = 1'b0;
    repeat (2) @(negedge clk);

    // Starvation: fetch and data (load via ALU result) held -> D D D F D D D F.
    c = cyc;
    for (int k = 0; k < 8; k++) begin
      if (k % 4 == 3) push(3'b001, 2'b00, 1'b1, 1'b0, 0, c + (k + 1) * (MEM_LAT + 1));
      else            push(3'b010, 2'b10, 1'b0, 1'b1, 0, c + (k + 1) * (MEM_LAT + 1));
    end
    bus.fetch_req = 1'b1; bus.data_req = 1'b1; bus.data_src = 1'b1; bus.data_we = 1'b0;
    for (int k = 0; k < 8; k++) begin
      wait_done((k % 4 == 3) ? 0 : 1, k == 7);
    end
    bus.data_req = 1'b0;
    repeat (2) @(negedge clk);

    // A running fetch is not preempted by a later exception.
    c = cyc;
    push(3'b001, 2'b00, 1'b1, 1'b0, 0, c + MEM_LAT + 1);
    push(3'b100, 2'b11, 1'b0, 1'b0, 0, c + 2 * (MEM_LAT + 1));
    bus.fetch_req = 1'b1;
    @(negedge clk);
    bus.exc_req = 1'b1;
    wait_done(0, 1);
    wait_done(2, 1);
    repeat (2) @(negedge clk);

    // Request dropped mid-transaction still completes.
    c = cyc;
    push(3'b010, 2'b01, 1'b0, 1'b1, 0, c + MEM_LAT + 1);
    bus.data_req = 1'b1; bus.data_src = 1'b0; bus.data_we = 1'b0;
    @(negedge clk);
    bus.data_req = 1'b0;
    wait_done(1, 0);
    repeat (2) @(negedge clk);

    // Reset during the second ACCESS cycle of a store: aborted, no done.
    bus.data_req = 1'b1; bus.data_src = 1'b1; bus.data_we = 1'b1;
    @(negedge clk);
    chk("abort_wr1", 32'(bus.mem_wr), 1);
    @(negedge clk);
    chk("abort_wr2", 32'(bus.mem_wr), 1);
    chk("abort_busy2", 32'(bus.busy), 1);
    reset_n = 1'b0;
    bus.data_req = 1'b0; bus.data_we = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(bus.busy), 0);
    chk("abort_mem_wr", 32'(bus.mem_wr), 0);
    chk("abort_mux", 32'(bus.mux_iord_control), 0);
    chk("abort_done", 32'(bus.data_done), 0);
    reset_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("abort_no_done", 32'(bus.data_done), 0);
    end

    repeat (3) @(negedge clk);
    chk("sb_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
